vram_arbiter: RTL and testbench

- Sits between the single-port VRAM / palette_mem and two requesters: the background/sprite renderer (read-only fetches) and the CPU register interface (PPUDATA reads/writes).
- Grants one access per cycle, steering address, write-enable and data.
- Returns read data one cycle after grant.
- Gives the renderer priority while rendering; a starvation guard prevents the CPU from waiting indefinitely.

---
 rtl/vram_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_vram_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port VRAM and palette_mem between the
// renderer (read-only fetches) and the CPU PPUDATA port. One access is
// granted per cycle; read data comes back one cycle after the grant.
// While rendering, the renderer has priority, but a CPU request that has
// been denied MAX_WAIT times is forced through. Outside rendering, access
// alternates round-robin. MAX_WAIT must fit in CNT_W bits.
module vram_arbiter #(
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        render,
  input  logic        ren_req,
  input  logic [13:0] ren_addr,
  output logic        ren_gnt,
  output logic        ren_valid,
  output logic [7:0]  ren_rdata,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [13:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_valid,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] VRAM_addr,
  output logic        VRAM_WE,
  output logic [7:0]  VRAM_data_in,
  input  logic [7:0]  VRAM_data_out,
  output logic [4:0]  pixel,
  output logic        palette_WE,
  output logic [7:0]  palette_data_in,
  input  logic [7:0]  palette_out
);

  typedef enum logic {OWN_CPU = 1'b0, OWN_REN = 1'b1} owner_t;

  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

  // Per-requester address decode; index 0 is the CPU, index 1 the renderer.
  logic [1:0][13:0] req_addr;
  logic [1:0]       dec_pal;
  logic [1:0][4:0]  dec_pixel;
  logic [1:0][15:0] dec_vaddr;

  assign req_addr = {ren_addr, cpu_addr};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_decode
      // 3F00-3FFF selects the palette.
      assign dec_pal[gi]   = (req_addr[gi][13:8] == 6'h3F);
      // Entries 10/14/18/1C alias the backdrop-colour slots 00/04/08/0C.
      assign dec_pixel[gi] = {req_addr[gi][4] & (req_addr[gi][1:0] != 2'b00),
                              req_addr[gi][3:0]};
      // 3000-3EFF mirrors the nametables at 2000-2EFF.
      assign dec_vaddr[gi] = (req_addr[gi][13:12] == 2'b11) ?
                             {2'b00, req_addr[gi] & 14'h2FFF} :
                             {2'b00, req_addr[gi]};
    end
  endgenerate

  // Architectural state.
  owner_t           last_owner_reg, last_owner_next;
  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic             s2_valid_reg, s2_valid_next;
  owner_t           s2_owner_reg, s2_owner_next;
  logic             s2_pal_reg, s2_pal_next;
  logic [15:0]      vram_addr_reg;
  logic [4:0]       pixel_reg;
  logic [7:0]       ren_rdata_reg, cpu_rdata_reg;

  logic             cpu_win, ren_win, any_win, sel_idx, sel_pal;
  logic [7:0]       rd_data;
  logic             unused_palette_bits;

  // Only six bits of a palette entry are meaningful.
  assign unused_palette_bits = ^palette_out[7:6];

  // Pick the single winner for this cycle; nothing is granted during reset.
  always_comb begin
    cpu_win = 1'b0;
    ren_win = 1'b0;
    if (!reset) begin
      if (render) begin
        if (cpu_req && (wait_cnt_reg == WAIT_LIMIT)) begin
          cpu_win = 1'b1;
        end else if (ren_req) begin
          ren_win = 1'b1;
        end else if (cpu_req) begin
          cpu_win = 1'b1;
        end
      end else begin
        if (cpu_req && ren_req) begin
          if (last_owner_reg == OWN_CPU) begin
            ren_win = 1'b1;
          end else begin
            cpu_win = 1'b1;
          end
        end else begin
          cpu_win = cpu_req;
          ren_win = ren_req;
        end
      end
    end
  end

  assign cpu_gnt = cpu_win;
  assign ren_gnt = ren_win;
  assign any_win = cpu_win | ren_win;
  assign sel_idx = ren_win;
  assign sel_pal = dec_pal[sel_idx];

  // Steer the winner onto the memory ports; idle cycles keep the last address.
  always_comb begin
    VRAM_addr  = vram_addr_reg;
    pixel      = pixel_reg;
    VRAM_WE    = 1'b0;
    palette_WE = 1'b0;
    if (any_win) begin
      if (sel_pal) begin
        pixel      = dec_pixel[sel_idx];
        palette_WE = cpu_win & cpu_we;
      end else begin
        VRAM_addr  = dec_vaddr[sel_idx];
        VRAM_WE    = cpu_win & cpu_we;
      end
    end
  end

  assign VRAM_data_in    = cpu_wdata;
  assign palette_data_in = cpu_wdata;

  // Next-state for starvation counter, round-robin pointer and read stage.
  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (!cpu_req || cpu_win) begin
      wait_cnt_next = '0;
    end else if (wait_cnt_reg != WAIT_LIMIT) begin
      wait_cnt_next = wait_cnt_reg + 1'b1;
    end

    last_owner_next = last_owner_reg;
    if (cpu_win) begin
      last_owner_next = OWN_CPU;
    end else if (ren_win) begin
      last_owner_next = OWN_REN;
    end

    s2_valid_next = any_win & ~(cpu_win & cpu_we);
    s2_owner_next = ren_win ? OWN_REN : OWN_CPU;
    s2_pal_next   = sel_pal;
  end

  // Register arbitration state, the read stage and the held addresses.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner_reg <= OWN_CPU;
      wait_cnt_reg   <= '0;
      s2_valid_reg   <= 1'b0;
      s2_owner_reg   <= OWN_CPU;
      s2_pal_reg     <= 1'b0;
      vram_addr_reg  <= '0;
      pixel_reg      <= '0;
    end else begin
      last_owner_reg <= last_owner_next;
      wait_cnt_reg   <= wait_cnt_next;
      s2_valid_reg   <= s2_valid_next;
      s2_owner_reg   <= s2_owner_next;
      s2_pal_reg     <= s2_pal_next;
      vram_addr_reg  <= VRAM_addr;
      pixel_reg      <= pixel;
    end
  end

  // Read return: a reset arriving while a read is in flight drops its valid.
  assign rd_data   = s2_pal_reg ? {2'b00, palette_out[5:0]} : VRAM_data_out;
  assign ren_valid = s2_valid_reg & (s2_owner_reg == OWN_REN) & ~reset;
  assign cpu_valid = s2_valid_reg & (s2_owner_reg == OWN_CPU) & ~reset;
  assign ren_rdata = ren_valid ? rd_data : ren_rdata_reg;
  assign cpu_rdata = cpu_valid ? rd_data : cpu_rdata_reg;

  // Keep the last returned byte per requester until its next valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      ren_rdata_reg <= '0;
      cpu_rdata_reg <= '0;
    end else begin
      if (ren_valid) begin
        ren_rdata_reg <= rd_data;
      end
      if (cpu_valid) begin
        cpu_rdata_reg <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: behavioural VRAM/palette memories behind the
// DUT, plus an independent reference copy of memory contents used to
// predict read data. Expected read bytes are queued per requester when a
// read is granted and compared when the matching valid appears.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        render;
  logic        ren_req;
  logic [13:0] ren_addr;
  logic        ren_gnt, ren_valid;
  logic [7:0]  ren_rdata;
  logic        cpu_req, cpu_we;
  logic [13:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_gnt, cpu_valid;
  logic [7:0]  cpu_rdata;
  logic [15:0] VRAM_addr;
  logic        VRAM_WE;
  logic [7:0]  VRAM_data_in;
  logic [7:0]  VRAM_data_out = 8'h00;
  logic [4:0]  pixel;
  logic        palette_WE;
  logic [7:0]  palette_data_in;
  logic [7:0]  palette_out = 8'h00;

  int checks_cnt = 0;
  int errors_cnt = 0;

  bit [7:0] vram_mem [65536];
  bit [7:0] pal_mem  [32];
  bit [7:0] ref_vram [65536];
  bit [7:0] ref_pal  [32];
  logic [7:0] ren_q [$];
  logic [7:0] cpu_q [$];

  always #5 clk = ~clk;

  vram_arbiter #(.MAX_WAIT(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .render(render),
    .ren_req(ren_req), .ren_addr(ren_addr), .ren_gnt(ren_gnt),
    .ren_valid(ren_valid), .ren_rdata(ren_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_valid(cpu_valid),
    .cpu_rdata(cpu_rdata),
    .VRAM_addr(VRAM_addr), .VRAM_WE(VRAM_WE), .VRAM_data_in(VRAM_data_in),
    .VRAM_data_out(VRAM_data_out),
    .pixel(pixel), .palette_WE(palette_WE), .palette_data_in(palette_data_in),
    .palette_out(palette_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Synchronous external memories; VRAM[0x2000] is preloaded with A5.
  always @(posedge clk) begin
    if (reset) vram_mem[16'h2000] <= 8'hA5;
    else if (VRAM_WE) vram_mem[VRAM_addr] <= VRAM_data_in;
    VRAM_data_out <= vram_mem[VRAM_addr];
    if (palette_WE) pal_mem[pixel] <= palette_data_in;
    palette_out <= pal_mem[pixel];
  end

  // Reference decode, written from the PPU memory map rather than bit masks.
  function automatic logic [7:0] ref_read(input logic [13:0] a);
    int idx;
    if (a >= 14'h3F00) begin
      idx = int'(a[4:0]);
      if (idx == 16 || idx == 20 || idx == 24 || idx == 28) idx -= 16;
      return {2'b00, ref_pal[idx][5:0]};
    end
    if (a >= 14'h3000) return ref_vram[int'(a) - 4096];
    return ref_vram[int'(a)];
  endfunction

  task automatic ref_write(input logic [13:0] a, input logic [7:0] d);
    int idx;
    if (a >= 14'h3F00) begin
      idx = int'(a[4:0]);
      if (idx == 16 || idx == 20 || idx == 24 || idx == 28) idx -= 16;
      ref_pal[idx] = d;
    end else if (a >= 14'h3000) begin
      ref_vram[int'(a) - 4096] = d;
    end else begin
      ref_vram[int'(a)] = d;
    end
  endtask

  // Scoreboard: compare returning reads, then enqueue predictions for new grants.
  always @(negedge clk) begin
    logic [7:0] exp_v;
    if (reset) begin
      ren_q.delete();
      cpu_q.delete();
      ref_vram[16'h2000] = 8'hA5;
    end else begin
      if (ren_valid) begin
        if (ren_q.size() == 0) check("ren_spurious_valid", 1, 0);
        else begin
          exp_v = ren_q.pop_front();
          check("ren_rdata", {24'h0, ren_rdata}, {24'h0, exp_v});
          $display("txn ren rdata=%02h expected=%02h", ren_rdata, exp_v);
        end
      end
      if (cpu_valid) begin
        if (cpu_q.size() == 0) check("cpu_spurious_valid", 1, 0);
        else begin
          exp_v = cpu_q.pop_front();
          check("cpu_rdata", {24'h0, cpu_rdata}, {24'h0, exp_v});
          $display("txn cpu rdata=%02h expected=%02h", cpu_rdata, exp_v);
        end
      end
      if (ren_gnt) ren_q.push_back(ref_read(ren_addr));
      if (cpu_gnt) begin
        if (cpu_we) ref_write(cpu_addr, cpu_wdata);
        else cpu_q.push_back(ref_read(cpu_addr));
      end
    end
  end

  // Issue one CPU access, wait (bounded) for its grant, capture grant-cycle outputs.
  task automatic cpu_op(input logic we, input logic [13:0] addr, input logic [7:0] data,
                        input int budget, output int waited, output logic [15:0] g_vaddr,
                        output logic [4:0] g_pix, output logic g_vwe, output logic g_pwe);
    cpu_we = we; cpu_addr = addr; cpu_wdata = data; cpu_req = 1'b1;
    waited = 0; g_vaddr = '0; g_pix = '0; g_vwe = 1'b0; g_pwe = 1'b0;
    forever begin
      @(negedge clk);
      if (cpu_gnt) begin
        g_vaddr = VRAM_addr; g_pix = pixel; g_vwe = VRAM_WE; g_pwe = palette_WE;
        break;
      end
      waited++;
      if (waited > budget) begin
        check("cpu_gnt_timeout", 0, 1);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
    $display("txn cpu %s addr=%04h wdata=%02h waited=%0d vaddr=%04h pixel=%02h",
             we ? "wr" : "rd", addr, data, waited, g_vaddr, g_pix);
  endtask

  task automatic ren_op(input logic [13:0] addr, input int budget, output int waited,
                        output logic [15:0] g_vaddr, output logic [4:0] g_pix);
    ren_addr = addr; ren_req = 1'b1;
    waited = 0; g_vaddr = '0; g_pix = '0;
    forever begin
      @(negedge clk);
      if (ren_gnt) begin
        g_vaddr = VRAM_addr; g_pix = pixel;
        break;
      end
      waited++;
      if (waited > budget) begin
        check("ren_gnt_timeout", 0, 1);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    ren_req = 1'b0;
    $display("txn ren rd addr=%04h waited=%0d vaddr=%04h", addr, waited, g_vaddr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w;
    logic [15:0] va;
    logic [4:0]  px;
    logic        vwe, pwe;

    reset = 1'b1; render = 1'b0;
    ren_req = 1'b0; ren_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ren_gnt", ren_gnt, 0);
    check("rst_cpu_gnt", cpu_gnt, 0);
    check("rst_valids", {ren_valid, cpu_valid}, 0);
    check("rst_we", {VRAM_WE, palette_WE}, 0);
    check("rst_vaddr", VRAM_addr, 0);
    check("rst_pixel", pixel, 0);
    check("rst_rdata", {ren_rdata, cpu_rdata}, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Renderer fetch while rendering: grant now, data next cycle.
    render = 1'b1; ren_req = 1'b1; ren_addr = 14'h2000;
    @(negedge clk);
    check("t1_ren_gnt", ren_gnt, 1);
    check("t1_cpu_gnt", cpu_gnt, 0);
    check("t1_vaddr", VRAM_addr, 16'h2000);
    @(posedge clk); #1;
    ren_req = 1'b0;
    @(negedge clk);
    check("t1_ren_valid", ren_valid, 1);
    check("t1_ren_rdata", ren_rdata, 8'hA5);
    check("t1_cpu_gnt_idle", cpu_gnt, 0);
    @(posedge clk); #1;

    // Palette writes/reads, including the backdrop mirrors.
    render = 1'b0;
    cpu_op(1'b1, 14'h3F11, 8'h2C, 4, w, va, px, vwe, pwe);
    check("t2_wr_wait", w, 0);
    check("t2_wr_pwe", pwe, 1);
    check("t2_wr_vwe", vwe, 0);
    check("t2_wr_pixel", px, 5'h11);
    cpu_op(1'b0, 14'h3F11, 8'h00, 4, w, va, px, vwe, pwe);
    check("t2_rd_pixel", px, 5'h11);
    check("t2_rd_pwe", pwe, 0);
    @(negedge clk);
    check("t2_rd_valid", cpu_valid, 1);
    check("t2_rd_data", cpu_rdata, 8'h2C);
    @(posedge clk); #1;
    cpu_op(1'b0, 14'h3F01, 8'h00, 4, w, va, px, vwe, pwe);
    check("t2_rd01_pixel", px, 5'h01);
    cpu_op(1'b1, 14'h3F10, 8'h1B, 4, w, va, px, vwe, pwe);
    check("t2_wr10_pixel", px, 5'h00);
    check("t2_wr10_pwe", pwe, 1);
    cpu_op(1'b0, 14'h3F00, 8'h00, 4, w, va, px, vwe, pwe);
    check("t2_rd00_pixel", px, 5'h00);
    @(negedge clk);
    check("t2_rd00_data", cpu_rdata, 8'h1B);
    @(posedge clk); #1;
    cpu_op(1'b0, 14'h3F1C, 8'h00, 4, w, va, px, vwe, pwe);
    check("t2_rd1c_pixel", px, 5'h0C);

    // Starvation guard under continuous renderer traffic.
    render = 1'b1; ren_req = 1'b1; ren_addr = 14'h0040;
    cpu_op(1'b0, 14'h0123, 8'h00, 20, w, va, px, vwe, pwe);
    check("t3_wait", w, 8);
    check("t3_vaddr", va, 16'h0123);
    @(negedge clk);
    check("t3_ren_regain", ren_gnt, 1);
    check("t3_cpu_idle", cpu_gnt, 0);
    @(posedge clk); #1;
    cpu_op(1'b0, 14'h0123, 8'h00, 20, w, va, px, vwe, pwe);
    check("t3_wait_again", w, 8);
    ren_req = 1'b0;

    // Round-robin after reset: renderer first since last owner resets to CPU.
    reset = 1'b1; render = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    ren_req = 1'b1; ren_addr = 14'h2000;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0123;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("t4_ren_gnt_c%0d", i), ren_gnt, (i % 2 == 0) ? 1 : 0);
      check($sformatf("t4_cpu_gnt_c%0d", i), cpu_gnt, (i % 2 == 0) ? 0 : 1);
      $display("txn rr cycle=%0d ren_gnt=%0b cpu_gnt=%0b", i, ren_gnt, cpu_gnt);
      @(posedge clk); #1;
    end
    ren_req = 1'b0; cpu_req = 1'b0;
    @(posedge clk); #1;

    // Nametable mirror: write via 3005, read back via 2005.
    cpu_op(1'b1, 14'h3005, 8'h77, 4, w, va, px, vwe, pwe);
    check("t5_vaddr", va, 16'h2005);
    check("t5_vwe", vwe, 1);
    check("t5_pwe", pwe, 0);
    ren_op(14'h2005, 4, w, va, px);
    check("t5_ren_vaddr", va, 16'h2005);
    @(negedge clk);
    check("t5_ren_valid", ren_valid, 1);
    check("t5_ren_rdata", ren_rdata, 8'h77);
    @(posedge clk); #1;
    @(negedge clk);
    check("t5_hold_valid", ren_valid, 0);
    check("t5_hold_rdata", ren_rdata, 8'h77);
    @(posedge clk); #1;

    // Reset lands on the cycle a renderer read would return.
    ren_op(14'h2000, 4, w, va, px);
    reset = 1'b1;
    @(negedge clk);
    check("t6_valid_dropped", ren_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t6_gnt", {ren_gnt, cpu_gnt}, 0);
    check("t6_ren_rdata", ren_rdata, 0);
    check("t6_cpu_rdata", cpu_rdata, 0);
    check("t6_vaddr", VRAM_addr, 0);
    check("t6_pixel", pixel, 0);
    check("t6_we", {VRAM_WE, palette_WE}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("t6_post_valid", {ren_valid, cpu_valid}, 0);
    @(posedge clk); #1;

    check("end_ren_q_empty", ren_q.size(), 0);
    check("end_cpu_q_empty", cpu_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
